// File: rtl/mutidata_rx.sv
// -----------------------------------------------------------------------------
// mutidata_rx
// Receive-side endpoint of a multi-bit req/ack four-phase CDC handshake.
// Everything here runs in the destination clock domain. The source's level
// request is synchronized, the source-held data word is captured once per
// four-phase cycle, and the word is presented downstream with valid/ready.
// A registered level acknowledge goes back to the source domain.
//
// Parameters
//   DW          data word width
//   SYNC_STAGES flops in the req synchronizer chain (2..4)
//   CNT_W       width of the completed-handoff counter
//
// Ports
//   clk_o      destination-domain clock, the only clock in the block
//   rst_o      asynchronous active-low reset
//   req        request level from the source domain (asynchronous)
//   din        source-held data, stable while req is high until ack is seen
//   ack        registered acknowledge level to the source domain
//   out_vld    dout holds a captured word
//   out_rdy    consumer accepts the word on out_vld && out_rdy at a clock edge
//   dout       captured word, registered
//   xfer_cnt   completed downstream handoffs, wraps silently
//   proto_err  sticky flag: source dropped req before ack was returned
// -----------------------------------------------------------------------------
module mutidata_rx #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_o,
  input  logic             rst_o,
  input  logic             req,
  input  logic [DW-1:0]    din,
  output logic             ack,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DW-1:0]    dout,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    ACK  = 2'b10
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;

  // Request synchronizer. Only the last stage is used by the FSM; the raw
  // req input never reaches any other logic. din is deliberately not
  // synchronized: the handshake guarantees it is stable when it is sampled.
  always_ff @(posedge clk_o or negedge rst_o) begin
    if (!rst_o) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req};
    end
  end

  assign req_s = req_sync[SYNC_STAGES-1];

  // Handshake FSM with registered outputs.
  // IDLE captures din on the first synchronized req and moves to HOLD.
  // HOLD keeps the word until the consumer takes it, then raises ack. A req
  // that falls while the word is still held is flagged but the word is still
  // delivered, so the source never loses a transfer it already launched.
  // ACK waits for the synchronized req to fall before a new capture can
  // happen, which is what rules out duplicate handoffs.
  always_ff @(posedge clk_o or negedge rst_o) begin
    if (!rst_o) begin
      state     <= IDLE;
      ack       <= 1'b0;
      out_vld   <= 1'b0;
      dout      <= '0;
      xfer_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack     <= 1'b0;
          out_vld <= 1'b0;
          if (req_s) begin
            dout    <= din;
            out_vld <= 1'b1;
            state   <= HOLD;
          end
        end

        HOLD: begin
          if (!req_s) begin
            proto_err <= 1'b1;
          end
          if (out_rdy) begin
            out_vld  <= 1'b0;
            ack      <= 1'b1;
            xfer_cnt <= xfer_cnt + CNT_W'(1);
            state    <= ACK;
          end
        end

        ACK: begin
          if (!req_s) begin
            ack   <= 1'b0;
            state <= IDLE;
          end
        end

        // Unreachable encoding: drop straight back to a quiet IDLE.
        default: begin
          ack     <= 1'b0;
          out_vld <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mutidata_rx.sv
// -----------------------------------------------------------------------------
// tb_mutidata_rx
// Directed self-checking bench for mutidata_rx. The DUT is built with a 4-bit
// transfer counter so that counter wrap-around can be reached quickly. The
// bench plays both the source side (req/din) and the consumer (out_rdy).
// Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mutidata_rx;

  localparam int DW    = 8;
  localparam int SYNC  = 2;
  localparam int CW    = 4;
  localparam int LIMIT = 40;

  logic          clk_o;
  logic          rst_o;
  logic          req;
  logic [DW-1:0] din;
  logic          ack;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] dout;
  logic [CW-1:0] xfer_cnt;
  logic          proto_err;

  int            n_checks;
  int            n_fail;
  int            cyc;
  logic [CW-1:0] exp_cnt;
  logic [DW-1:0] got[$];

  mutidata_rx #(
    .DW          (DW),
    .SYNC_STAGES (SYNC),
    .CNT_W       (CW)
  ) dut (
    .clk_o     (clk_o),
    .rst_o     (rst_o),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .dout      (dout),
    .xfer_cnt  (xfer_cnt),
    .proto_err (proto_err)
  );

  // 10 ns destination clock.
  initial clk_o = 1'b0;
  always #5 clk_o = ~clk_o;

  // Advance n clock cycles, logging every word accepted by the consumer.
  // A word is taken at the rising edge that follows a falling edge where
  // out_vld && out_rdy is seen.
  task automatic tick_rec(input int n);
    for (int i = 0; i < n; i++) begin
      if (out_vld && out_rdy) got.push_back(dout);
      @(negedge clk_o);
      cyc++;
    end
  endtask

  // Keep source-side actions on every second destination cycle, i.e. a
  // source clock running at half the destination rate.
  task automatic align_src();
    if (cyc % 2 != 0) tick_rec(1);
  endtask

  task automatic wait_vld(output int edges, output bit ok);
    edges = 0;
    while (!out_vld && edges < LIMIT) begin
      tick_rec(1);
      edges++;
    end
    ok = (out_vld === 1'b1);
  endtask

  task automatic wait_ack(input logic lvl, output int edges, output bit ok);
    edges = 0;
    while (ack !== lvl && edges < LIMIT) begin
      tick_rec(1);
      edges++;
    end
    ok = (ack === lvl);
  endtask

  // Drive one complete four-phase cycle with out_rdy already high.
  task automatic run_transfer(input logic [DW-1:0] w, output bit ok);
    int e;
    bit ok1;
    bit ok2;
    din = w;
    req = 1'b1;
    wait_ack(1'b1, e, ok1);
    req = 1'b0;
    wait_ack(1'b0, e, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    rst_o   = 1'b0;
    req     = 1'b1;
    din     = 8'hFF;
    out_rdy = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({ack, out_vld, dout, xfer_cnt, proto_err} !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_hold cycle %0d: ack=%b vld=%b dout=%h cnt=%h err=%b, need all zero",
                 i, ack, out_vld, dout, xfer_cnt, proto_err);
      end
      tick_rec(1);
    end
    req   = 1'b0;
    rst_o = 1'b1;
    tick_rec(4);
    exp_cnt = '0;
    n_checks++;
    if (out_vld !== 1'b0 || ack !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_release: vld=%b ack=%b, need 0 0", out_vld, ack);
    end
  endtask

  task automatic test_single();
    int e;
    bit ok;
    got.delete();
    din     = 8'd4;
    out_rdy = 1'b1;
    req     = 1'b1;
    wait_vld(e, ok);
    n_checks++;
    if (!ok || e < SYNC + 1 || e > SYNC + 2) begin
      n_fail++;
      $display("[TB] FAIL single_vld_latency: %0d edges (vld=%b), need %0d..%0d", e, out_vld, SYNC + 1, SYNC + 2);
    end
    n_checks++;
    if (dout !== 8'd4) begin
      n_fail++;
      $display("[TB] FAIL single_dout: got %h need 04", dout);
    end
    n_checks++;
    if (ack !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_ack_before_hs: got %b need 0", ack);
    end
    tick_rec(1);
    exp_cnt = exp_cnt + 1'b1;
    n_checks++;
    if (ack !== 1'b1 || out_vld !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_handshake: ack=%b vld=%b, need 1 0", ack, out_vld);
    end
    req = 1'b0;
    wait_ack(1'b0, e, ok);
    n_checks++;
    if (!ok || e < SYNC + 1 || e > SYNC + 2) begin
      n_fail++;
      $display("[TB] FAIL single_ack_fall: %0d edges (ack=%b), need %0d..%0d", e, ack, SYNC + 1, SYNC + 2);
    end
    tick_rec(3);
    n_checks++;
    if (xfer_cnt !== exp_cnt) begin
      n_fail++;
      $display("[TB] FAIL single_cnt: got %0d need %0d", xfer_cnt, exp_cnt);
    end
    n_checks++;
    if (got.size() != 1 || out_vld !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_handoffs: %0d handoffs vld=%b, need 1 and 0", got.size(), out_vld);
    end
  endtask

  task automatic test_backpressure();
    int e;
    bit ok;
    din     = 8'd10;
    out_rdy = 1'b0;
    req     = 1'b1;
    wait_vld(e, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL bp_vld_timeout: vld=%b need 1", out_vld);
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_vld !== 1'b1 || dout !== 8'd10 || ack !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bp_hold cycle %0d: vld=%b dout=%h ack=%b, need 1 0a 0", i, out_vld, dout, ack);
      end
      tick_rec(1);
    end
    out_rdy = 1'b1;
    tick_rec(1);
    exp_cnt = exp_cnt + 1'b1;
    n_checks++;
    if (ack !== 1'b1 || out_vld !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_release: ack=%b vld=%b, need 1 0", ack, out_vld);
    end
    n_checks++;
    if (xfer_cnt !== exp_cnt) begin
      n_fail++;
      $display("[TB] FAIL bp_cnt: got %0d need %0d", xfer_cnt, exp_cnt);
    end
    req = 1'b0;
    wait_ack(1'b0, e, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL bp_ack_fall_timeout: ack=%b need 0", ack);
    end
  endtask

  task automatic test_sequence();
    logic [DW-1:0] words [4];
    int            e;
    bit            ok1;
    bit            ok2;
    words[0] = 8'd4;
    words[1] = 8'd10;
    words[2] = 8'd5;
    words[3] = 8'd8;
    got.delete();
    out_rdy = 1'b1;
    // Each step takes whole source cycles; the extra cycles model the
    // source-side ack synchronizer.
    for (int k = 0; k < 4; k++) begin
      align_src();
      din = words[k];
      req = 1'b1;
      wait_ack(1'b1, e, ok1);
      tick_rec(4);
      align_src();
      req = 1'b0;
      wait_ack(1'b0, e, ok2);
      tick_rec(4);
      exp_cnt = exp_cnt + 1'b1;
      n_checks++;
      if (!ok1 || !ok2) begin
        n_fail++;
        $display("[TB] FAIL seq_timeout word %0d: ack rise ok=%b fall ok=%b", k, ok1, ok2);
      end
    end
    n_checks++;
    if (got.size() != 4) begin
      n_fail++;
      $display("[TB] FAIL seq_count: %0d handoffs, need 4", got.size());
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= got.size() || got[k] !== words[k]) begin
        n_fail++;
        $display("[TB] FAIL seq_word %0d: got %h need %h", k, (k < got.size()) ? got[k] : 8'hxx, words[k]);
      end
    end
    n_checks++;
    if (xfer_cnt !== exp_cnt || proto_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL seq_status: cnt=%0d err=%b, need %0d 0", xfer_cnt, proto_err, exp_cnt);
    end
  endtask

  task automatic test_proto_err();
    int e;
    bit ok;
    got.delete();
    din     = 8'h5A;
    out_rdy = 1'b0;
    req     = 1'b1;
    wait_vld(e, ok);
    req = 1'b0;
    tick_rec(SYNC + 2);
    n_checks++;
    if (!ok || proto_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL perr_set: vld_ok=%b err=%b, need 1 1", ok, proto_err);
    end
    n_checks++;
    if (out_vld !== 1'b1 || dout !== 8'h5A || ack !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL perr_hold: vld=%b dout=%h ack=%b, need 1 5a 0", out_vld, dout, ack);
    end
    out_rdy = 1'b1;
    tick_rec(1);
    exp_cnt = exp_cnt + 1'b1;
    n_checks++;
    if (ack !== 1'b1 || out_vld !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL perr_ack_high: ack=%b vld=%b, need 1 0", ack, out_vld);
    end
    tick_rec(1);
    n_checks++;
    if (ack !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL perr_ack_low: ack=%b need 0", ack);
    end
    tick_rec(4);
    n_checks++;
    if (got.size() != 1 || got[0] !== 8'h5A) begin
      n_fail++;
      $display("[TB] FAIL perr_delivery: %0d handoffs, need exactly one of 5a", got.size());
    end
    n_checks++;
    if (proto_err !== 1'b1 || out_vld !== 1'b0 || xfer_cnt !== exp_cnt) begin
      n_fail++;
      $display("[TB] FAIL perr_after: err=%b vld=%b cnt=%0d, need 1 0 %0d", proto_err, out_vld, xfer_cnt, exp_cnt);
    end
    din = 8'h33;
    req = 1'b1;
    wait_ack(1'b1, e, ok);
    exp_cnt = exp_cnt + 1'b1;
    n_checks++;
    if (!ok || dout !== 8'h33 || xfer_cnt !== exp_cnt) begin
      n_fail++;
      $display("[TB] FAIL perr_next_xfer: ack_ok=%b dout=%h cnt=%0d, need 1 33 %0d", ok, dout, xfer_cnt, exp_cnt);
    end
    req = 1'b0;
    wait_ack(1'b0, e, ok);
    n_checks++;
    if (!ok || proto_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL perr_sticky: ack_low_ok=%b err=%b, need 1 1", ok, proto_err);
    end
  endtask

  task automatic test_reset_in_ack();
    int e;
    bit ok;
    int n_ok;
    din     = 8'h77;
    out_rdy = 1'b1;
    req     = 1'b1;
    wait_ack(1'b1, e, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL rst_ack_reach: ack=%b need 1", ack);
    end
    // Assert reset between clock edges; outputs must clear without an edge.
    #2;
    rst_o = 1'b0;
    #1;
    exp_cnt = '0;
    n_checks++;
    if (ack !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_async_ack: got %b need 0", ack);
    end
    n_checks++;
    if ({out_vld, dout, xfer_cnt, proto_err} !== '0) begin
      n_fail++;
      $display("[TB] FAIL rst_async_regs: vld=%b dout=%h cnt=%h err=%b, need all zero",
               out_vld, dout, xfer_cnt, proto_err);
    end
    out_rdy = 1'b0;
    @(negedge clk_o);
    tick_rec(2);
    n_checks++;
    if ({ack, out_vld, dout, xfer_cnt} !== '0) begin
      n_fail++;
      $display("[TB] FAIL rst_no_capture: ack=%b vld=%b dout=%h cnt=%h, need all zero", ack, out_vld, dout, xfer_cnt);
    end
    rst_o = 1'b1;
    wait_vld(e, ok);
    n_checks++;
    if (!ok || dout !== 8'h77 || xfer_cnt !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL rst_recapture: vld_ok=%b dout=%h cnt=%0d, need 1 77 0", ok, dout, xfer_cnt);
    end
    out_rdy = 1'b1;
    tick_rec(1);
    exp_cnt = exp_cnt + 1'b1;
    n_checks++;
    if (xfer_cnt !== exp_cnt || ack !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_redeliver: cnt=%0d ack=%b, need %0d 1", xfer_cnt, ack, exp_cnt);
    end
    req = 1'b0;
    wait_ack(1'b0, e, ok);
    n_ok = 0;
    for (int k = 0; k < 16; k++) begin
      run_transfer(DW'(k * 3 + 1), ok);
      if (ok) n_ok++;
      exp_cnt = exp_cnt + 1'b1;
    end
    tick_rec(2);
    n_checks++;
    if (n_ok != 16) begin
      n_fail++;
      $display("[TB] FAIL wrap_transfers: %0d completed, need 16", n_ok);
    end
    n_checks++;
    if (xfer_cnt !== exp_cnt || xfer_cnt !== 4'd1) begin
      n_fail++;
      $display("[TB] FAIL wrap_cnt: got %0d need 1", xfer_cnt);
    end
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wrap_err: got %b need 0", proto_err);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    exp_cnt  = '0;
    rst_o    = 1'b0;
    req      = 1'b0;
    din      = '0;
    out_rdy  = 1'b0;
    @(negedge clk_o);
    test_reset();
    test_single();
    test_backpressure();
    test_sequence();
    test_proto_err();
    test_reset_in_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
